sprite_reg_scheduler: RTL and testbench
=======================================

SPRITE_REG_SCHEDULER -- requirements
Module: sprite_reg_scheduler

Interface
REQ-001 clk  input  1  system clock (50 MHz); the only clock domain.
REQ-002 reset_n  input  1  reset; asynchronous assert, active-low.
REQ-003 chipselect  input  1  bus select; a write occurs when chipselect && write.
REQ-004 write  input  1  bus write strobe.
REQ-005 address  input  9  word address (map in REQ-013).
REQ-006 writedata  input  32  write data.
REQ-007 vcount  input  10  current VGA line from the timing generator (0..524).
REQ-008 sprite_x  output  80  active X, slot n at bits [10n+9:10n], n = 0..7.
REQ-009 sprite_y  output  80  active Y, same packing as sprite_x.
REQ-010 sprite_en  output  8  active enable mask, bit n = slot n.
REQ-011 anim_phase  output  2  run-cycle phase 0,1,2; anim_toggle output 1 is its companion two-phase flap bit.
REQ-012 frame_count  output  16  vblank counter; commit_pending output 1; commit_done output 1 (one-cycle pulse).

Function
REQ-013 Address map: 0-7 shadow X[n] <= writedata[9:0]; 8-15 shadow Y[n-8] <= writedata[9:0]; 16 shadow enable <= writedata[7:0]; 17 control: bit0 = commit request (self-clearing), bit1 = immediate mode (sticky); 18 anim_period <= writedata[7:0]; other addresses are ignored.
REQ-014 vblank_start is a one-cycle internal pulse, asserted when vcount == 480 and the registered previous vcount != 480.
REQ-015 State machine: IDLE, WAIT_VB, COMMIT, DONE; reset state is IDLE.
REQ-016 IDLE -> WAIT_VB on a commit request; commit_pending = 1 in WAIT_VB and COMMIT.
REQ-017 WAIT_VB -> COMMIT on vblank_start; a request coincident with vblank_start while in IDLE goes directly to COMMIT on that edge.
REQ-018 COMMIT copies one item per cycle with index 0..8: index 0-7 copies shadow X/Y of slot k into active; index 8 copies the enable mask; 9 cycles in total.
REQ-019 A copy uses the shadow value before any same-cycle bus write; that write lands in shadow only.
REQ-020 COMMIT -> DONE after index 8; DONE pulses commit_done for 1 cycle, then -> IDLE; commit_pending is 0 in DONE.
REQ-021 A commit request received during COMMIT or DONE sets a latched request; from DONE the FSM then enters WAIT_VB instead of IDLE.
REQ-022 Requests in WAIT_VB are absorbed; there is no queueing beyond one pending commit.
REQ-023 Immediate mode = 1: position/enable writes update shadow and active on the same edge, and commit requests still run normally.
REQ-024 frame_count increments by 1 on every vblank_start and wraps 0xFFFF -> 0.
REQ-025 Animation divider counts vblank_starts; when it reaches max(anim_period,1) it clears, anim_phase advances 0->1->2->0, and anim_toggle inverts.
REQ-026 Writing anim_period clears the divider; anim_phase and anim_toggle are unchanged.
REQ-027 All outputs are registered; there is no combinational path from bus inputs to outputs.

Reset
REQ-028 On reset_n low, immediately: all shadow and active X/Y = 0, enables = 0, immediate mode = 0, anim_period = 6, divider = 0, anim_phase = 0, anim_toggle = 0, frame_count = 0, state = IDLE, commit_pending = 0, commit_done = 0, latched request cleared.
REQ-029 Reset during COMMIT abandons the copy; active registers return to reset values, not to a partial copy.

Verification
REQ-030 Write X[2] = 300, Y[2] = 200, enable = 0x04, then commit at vcount = 100 -> active unchanged until vcount reaches 480; sprite_x[29:20] = 300 nine cycles later; commit_done pulses once.
REQ-031 Commit request on the same edge as vblank_start from IDLE -> COMMIT begins immediately, and commit_pending falls in DONE.
REQ-032 During COMMIT index 3, write X[1] = 50 and X[5] = 60 -> after DONE, active X[1] is unchanged and active X[5] = 60; a new commit then applies X[1] = 50.
REQ-033 anim_period = 2 over 12 vblanks -> anim_phase sequence 0,1,2,0,1,2 changing every 2 frames, anim_toggle inverting each step; anim_period = 0 advances every frame.
REQ-034 Immediate mode on, write Y[7] = 400 -> sprite_y[79:70] = 400 on the next cycle, without a commit.
REQ-035 Assert reset_n low mid-COMMIT -> all outputs at reset values without waiting for a clock edge, and state = IDLE after release.

Source files
------------

// File: rtl/sprite_reg_scheduler.sv
`default_nettype none
// ============================================================================
// sprite_reg_scheduler: shadow/active sprite registers with vblank-aligned
// commit, frame counter and run-cycle animation divider.
// Revision: 1.0
// ============================================================================
module sprite_reg_scheduler (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic        write,
  input  logic [8:0]  address,
  input  logic [31:0] writedata,
  input  logic [9:0]  vcount,
  output logic [79:0] sprite_x,
  output logic [79:0] sprite_y,
  output logic [7:0]  sprite_en,
  output logic [1:0]  anim_phase,
  output logic        anim_toggle,
  output logic [15:0] frame_count,
  output logic        commit_pending,
  output logic        commit_done
);

  localparam logic [8:0] c_ADDR_EN     = 9'd16;
  localparam logic [8:0] c_ADDR_CTRL   = 9'd17;
  localparam logic [8:0] c_ADDR_PERIOD = 9'd18;
  localparam logic [9:0] c_VBLANK_LINE = 10'd480;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_VB = 2'd1,
    S_COMMIT  = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [9:0]  r_shx    [8];
  logic [9:0]  r_shy    [8];
  logic [9:0]  r_actx   [8];
  logic [9:0]  r_acty   [8];
  logic [7:0]  r_sh_en;
  logic [7:0]  r_act_en;
  logic        r_imm;
  logic [7:0]  r_period;
  logic [7:0]  r_div;
  logic [1:0]  r_phase;
  logic        r_toggle;
  logic [15:0] r_frame;
  logic [9:0]  r_vcount_prev;
  logic [3:0]  r_idx;
  logic        r_latch;
  logic        r_pending;
  logic        r_done;

  logic        w_wr;
  logic        w_req;
  logic        w_vb;
  logic        w_wr_x;
  logic        w_wr_y;
  logic        w_wr_en;
  logic        w_wr_period;
  logic [7:0]  w_period_eff;
  logic        w_div_hit;
  logic        w_unused;

  assign w_wr        = chipselect & write;
  assign w_wr_x      = w_wr && (address[8:3] == 6'd0);
  assign w_wr_y      = w_wr && (address[8:3] == 6'd1);
  assign w_wr_en     = w_wr && (address == c_ADDR_EN);
  assign w_wr_period = w_wr && (address == c_ADDR_PERIOD);
  assign w_req       = w_wr && (address == c_ADDR_CTRL) && writedata[0];
  assign w_vb        = (vcount == c_VBLANK_LINE) && (r_vcount_prev != c_VBLANK_LINE);
  assign w_period_eff = (r_period == 8'd0) ? 8'd1 : r_period;
  assign w_div_hit    = (r_div >= (w_period_eff - 8'd1));
  assign w_unused     = &{1'b0, writedata[31:10]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_req) w_next_state = w_vb ? S_COMMIT : S_WAIT_VB;
      S_WAIT_VB: if (w_vb) w_next_state = S_COMMIT;
      S_COMMIT:  if (r_idx == 4'd8) w_next_state = S_DONE;
      S_DONE:    w_next_state = (r_latch || w_req) ? S_WAIT_VB : S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Flags follow the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= 1'b0;
      r_done    <= 1'b0;
      r_latch   <= 1'b0;
      r_idx     <= 4'd0;
    end else begin
      r_pending <= (w_next_state == S_WAIT_VB) || (w_next_state == S_COMMIT);
      r_done    <= (w_next_state == S_DONE);
      if (r_state == S_COMMIT && w_req) r_latch <= 1'b1;
      else if (r_state == S_DONE)       r_latch <= 1'b0;
      r_idx <= (r_state == S_COMMIT) ? r_idx + 4'd1 : 4'd0;
    end
  end

  // Copies read shadow before this edge's bus write; an immediate-mode write
  // comes later in the block so it wins over a same-slot copy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < 8; n++) begin
        r_shx[n]  <= 10'd0;
        r_shy[n]  <= 10'd0;
        r_actx[n] <= 10'd0;
        r_acty[n] <= 10'd0;
      end
      r_sh_en  <= 8'd0;
      r_act_en <= 8'd0;
      r_imm    <= 1'b0;
    end else begin
      if (r_state == S_COMMIT) begin
        if (r_idx[3]) begin
          r_act_en <= r_sh_en;
        end else begin
          r_actx[r_idx[2:0]] <= r_shx[r_idx[2:0]];
          r_acty[r_idx[2:0]] <= r_shy[r_idx[2:0]];
        end
      end
      if (w_wr_x) begin
        r_shx[address[2:0]] <= writedata[9:0];
        if (r_imm) r_actx[address[2:0]] <= writedata[9:0];
      end
      if (w_wr_y) begin
        r_shy[address[2:0]] <= writedata[9:0];
        if (r_imm) r_acty[address[2:0]] <= writedata[9:0];
      end
      if (w_wr_en) begin
        r_sh_en <= writedata[7:0];
        if (r_imm) r_act_en <= writedata[7:0];
      end
      if (w_wr && address == c_ADDR_CTRL) r_imm <= writedata[1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vcount_prev <= 10'd0;
      r_frame       <= 16'd0;
      r_period      <= 8'd6;
      r_div         <= 8'd0;
      r_phase       <= 2'd0;
      r_toggle      <= 1'b0;
    end else begin
      r_vcount_prev <= vcount;
      if (w_vb) r_frame <= r_frame + 16'd1;
      if (w_wr_period) begin
        r_period <= writedata[7:0];
        r_div    <= 8'd0;
      end else if (w_vb) begin
        if (w_div_hit) begin
          r_div    <= 8'd0;
          r_phase  <= (r_phase == 2'd2) ? 2'd0 : r_phase + 2'd1;
          r_toggle <= ~r_toggle;
        end else begin
          r_div <= r_div + 8'd1;
        end
      end
    end
  end

  for (genvar n = 0; n < 8; n++) begin : g_pack
    assign sprite_x[10*n +: 10] = r_actx[n];
    assign sprite_y[10*n +: 10] = r_acty[n];
  end

  assign sprite_en      = r_act_en;
  assign anim_phase     = r_phase;
  assign anim_toggle    = r_toggle;
  assign frame_count    = r_frame;
  assign commit_pending = r_pending;
  assign commit_done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sprite_reg_scheduler.sv
`default_nettype none
// ============================================================================
// tb_sprite_reg_scheduler: directed stimulus with a commit scoreboard.
// Revision: 1.0
// ============================================================================
module tb_sprite_reg_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic [8:0]  address = 9'd0;
  logic [31:0] writedata = 32'd0;
  logic [9:0]  vcount = 10'd0;
  logic [79:0] sprite_x;
  logic [79:0] sprite_y;
  logic [7:0]  sprite_en;
  logic [1:0]  anim_phase;
  logic        anim_toggle;
  logic [15:0] frame_count;
  logic        commit_pending;
  logic        commit_done;

  sprite_reg_scheduler dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .write(write),
    .address(address), .writedata(writedata), .vcount(vcount),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_en(sprite_en),
    .anim_phase(anim_phase), .anim_toggle(anim_toggle),
    .frame_count(frame_count), .commit_pending(commit_pending),
    .commit_done(commit_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [79:0] x;
    logic [79:0] y;
    logic [7:0]  en;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [79:0] f10(input int slot, input int v);
    logic [79:0] t;
    t = 80'(v);
    return t << (10 * slot);
  endfunction

  task automatic push(input logic [79:0] x, input logic [79:0] y, input logic [7:0] en);
    exp_t e;
    e.x = x; e.y = y; e.en = en;
    q.push_back(e);
  endtask

  // Every commit_done pulse must match the oldest queued commit.
  always @(negedge clk) begin
    if (reset_n && commit_done) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_commit_done: got pulse expected none");
      end else begin
        exp_t e;
        e = q.pop_front();
        check("commit_x", sprite_x, e.x);
        check("commit_y", sprite_y, e.y);
        check("commit_en", {72'd0, sprite_en}, {72'd0, e.en});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic [8:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (commit_done) begin
        found = 1'b1;
        break;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL %s: got no commit_done expected pulse within 40 cycles", name);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #2 reset_n = 1'b0;
    #1;
    check("rst_x", sprite_x, 80'd0);
    check("rst_phase", {78'd0, anim_phase}, 80'd0);
    check("rst_frame", {64'd0, frame_count}, 80'd0);
    check("rst_pending", {79'd0, commit_pending}, 80'd0);
    ticks(2);
    reset_n = 1'b1;
    tick();

    // Animation, period 2 then period 0
    bus_write(9'd18, 32'd2);
    for (int i = 1; i <= 12; i++) begin
      vcount = 10'd480; tick();
      @(negedge clk);
      check($sformatf("anim2_phase_%0d", i), {78'd0, anim_phase}, 80'((i / 2) % 3));
      check($sformatf("anim2_toggle_%0d", i), {79'd0, anim_toggle}, 80'((i / 2) % 2));
      vcount = 10'd0; tick();
    end
    bus_write(9'd18, 32'd0);
    for (int j = 1; j <= 3; j++) begin
      vcount = 10'd480; tick();
      @(negedge clk);
      check($sformatf("anim0_phase_%0d", j), {78'd0, anim_phase}, 80'(j % 3));
      check($sformatf("anim0_toggle_%0d", j), {79'd0, anim_toggle}, 80'(j % 2));
      vcount = 10'd0; tick();
    end
    check("frame_after_anim", {64'd0, frame_count}, 80'd15);

    // Commit waits for vblank
    vcount = 10'd100; tick();
    bus_write(9'd2, 32'd300);
    bus_write(9'd10, 32'd200);
    bus_write(9'd16, 32'h04);
    push(f10(2, 300), f10(2, 200), 8'h04);
    bus_write(9'd17, 32'd1);
    ticks(2);
    @(negedge clk);
    check("wait_pending", {79'd0, commit_pending}, 80'd1);
    check("wait_x_unchanged", sprite_x, 80'd0);
    bus_write(9'd17, 32'd1);
    vcount = 10'd480; tick();
    ticks(8);
    @(negedge clk);
    check("idx8_no_done", {79'd0, commit_done}, 80'd0);
    check("idx8_en_not_yet", {72'd0, sprite_en}, 80'd0);
    check("idx8_x2", {70'd0, sprite_x[29:20]}, 80'd300);
    tick();
    @(negedge clk);
    check("done_pulse", {79'd0, commit_done}, 80'd1);
    check("done_pending_low", {79'd0, commit_pending}, 80'd0);
    tick();
    @(negedge clk);
    check("done_one_cycle", {79'd0, commit_done}, 80'd0);
    check("absorbed_req", {79'd0, commit_pending}, 80'd0);

    // Request coincident with vblank from IDLE
    bus_write(9'd0, 32'd11);
    vcount = 10'd479; tick();
    push(f10(0, 11) | f10(2, 300), f10(2, 200), 8'h04);
    vcount = 10'd480;
    bus_write(9'd17, 32'd1);
    @(negedge clk);
    check("coinc_pending", {79'd0, commit_pending}, 80'd1);
    ticks(8);
    tick();
    @(negedge clk);
    check("coinc_done", {79'd0, commit_done}, 80'd1);
    check("coinc_pending_low", {79'd0, commit_pending}, 80'd0);
    tick();

    // Bus writes during COMMIT land in shadow only
    vcount = 10'd400; tick();
    push(f10(0, 11) | f10(2, 300) | f10(5, 60), f10(2, 200), 8'h04);
    vcount = 10'd480;
    bus_write(9'd17, 32'd1);
    ticks(3);
    bus_write(9'd3, 32'd33);
    bus_write(9'd5, 32'd60);
    bus_write(9'd1, 32'd50);
    wait_done("mid_commit_done");

    // New commit applies X1/X3; a request during COMMIT is latched
    vcount = 10'd400; tick();
    push(f10(0, 11) | f10(1, 50) | f10(2, 300) | f10(3, 33) | f10(5, 60), f10(2, 200), 8'h04);
    push(f10(0, 11) | f10(1, 50) | f10(2, 300) | f10(3, 33) | f10(5, 60), f10(2, 200), 8'h04);
    vcount = 10'd480;
    bus_write(9'd17, 32'd1);
    ticks(2);
    bus_write(9'd17, 32'd1);
    wait_done("recommit_done");
    @(negedge clk);
    check("latched_pending", {79'd0, commit_pending}, 80'd1);
    vcount = 10'd400; tick();
    vcount = 10'd480; tick();
    wait_done("latched_done");
    check("frame_after_commits", {64'd0, frame_count}, 80'd20);

    // Immediate mode
    bus_write(9'd17, 32'd2);
    bus_write(9'd15, 32'd400);
    @(negedge clk);
    check("imm_y7", {70'd0, sprite_y[79:70]}, 80'd400);
    check("imm_no_pending", {79'd0, commit_pending}, 80'd0);
    bus_write(9'd17, 32'd0);

    // Asynchronous reset mid-COMMIT
    vcount = 10'd400; tick();
    vcount = 10'd480;
    bus_write(9'd17, 32'd1);
    ticks(3);
    #2 reset_n = 1'b0;
    #1;
    check("arst_x", sprite_x, 80'd0);
    check("arst_y", sprite_y, 80'd0);
    check("arst_en", {72'd0, sprite_en}, 80'd0);
    check("arst_pending", {79'd0, commit_pending}, 80'd0);
    check("arst_frame", {64'd0, frame_count}, 80'd0);
    check("arst_toggle", {79'd0, anim_toggle}, 80'd0);
    @(negedge clk);
    reset_n = 1'b1;
    vcount = 10'd0; tick();
    vcount = 10'd480; tick();
    ticks(2);
    @(negedge clk);
    check("post_rst_idle", {79'd0, commit_pending}, 80'd0);
    check("post_rst_x", sprite_x, 80'd0);
    check("post_rst_frame", {64'd0, frame_count}, 80'd1);
    tick();

    check("queue_drained", 80'(q.size()), 80'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
